// File: rtl/id_stage.sv
// Instruction-decode stage: register file with write-back bypass, control decoder,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int DW   = 16,
    parameter int PCW  = 6,
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PCW-1:0]          id_pc,
    input  logic [15:0]             id_inst,
    input  logic                    id_valid,
    input  logic                    flush,
    input  logic                    wb_we,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [DW-1:0]           wb_data,
    output logic                    stall,
    output logic                    ex_valid,
    output logic [PCW-1:0]          ex_pc,
    output logic [DW-1:0]           ex_rs_data,
    output logic [DW-1:0]           ex_rt_data,
    output logic [DW-1:0]           ex_imm,
    output logic [$clog2(NREG)-1:0] ex_rs,
    output logic [$clog2(NREG)-1:0] ex_rt,
    output logic [$clog2(NREG)-1:0] ex_dest,
    output logic [2:0]              ex_alu_op,
    output logic                    ex_alu_src,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_reg_write,
    output logic                    ex_branch,
    output logic                    ex_jump
);
    localparam int AW = $clog2(NREG);

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_J     = 4'h5;

    localparam logic [2:0] ALU_SUB      = 3'b001;
    localparam logic [2:0] FUNCT_LAST   = 3'b100;

    // Instruction fields
    logic [3:0]    w_opcode;
    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic [AW-1:0] w_rd;
    logic [2:0]    w_funct;
    logic [5:0]    w_imm6;

    assign w_opcode = id_inst[15:12];
    assign w_rs     = id_inst[11:9];
    assign w_rt     = id_inst[8:6];
    assign w_rd     = id_inst[5:3];
    assign w_funct  = id_inst[2:0];
    assign w_imm6   = id_inst[5:0];

    // Decoded control
    logic          w_legal;
    logic          w_uses_rs;
    logic          w_uses_rt;
    logic [AW-1:0] w_dest;
    logic [2:0]    w_alu_op;
    logic          w_alu_src;
    logic          w_mem_read;
    logic          w_mem_write;
    logic          w_reg_write;
    logic          w_branch;
    logic          w_jump;
    logic [DW-1:0] w_imm;

    always_comb begin
        w_legal     = 1'b0;
        w_uses_rs   = 1'b0;
        w_uses_rt   = 1'b0;
        w_dest      = '0;
        w_alu_op    = 3'b000;
        w_alu_src   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                if (w_funct <= FUNCT_LAST) begin
                    w_legal     = 1'b1;
                    w_uses_rs   = 1'b1;
                    w_uses_rt   = 1'b1;
                    w_alu_op    = w_funct;
                    w_dest      = w_rd;
                    w_reg_write = 1'b1;
                end
            end
            OP_ADDI: begin
                w_legal     = 1'b1;
                w_uses_rs   = 1'b1;
                w_alu_src   = 1'b1;
                w_dest      = w_rt;
                w_reg_write = 1'b1;
            end
            OP_LW: begin
                w_legal     = 1'b1;
                w_uses_rs   = 1'b1;
                w_alu_src   = 1'b1;
                w_mem_read  = 1'b1;
                w_dest      = w_rt;
                w_reg_write = 1'b1;
            end
            OP_SW: begin
                w_legal     = 1'b1;
                w_uses_rs   = 1'b1;
                w_uses_rt   = 1'b1;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_legal   = 1'b1;
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
                w_alu_op  = ALU_SUB;
                w_branch  = 1'b1;
            end
            OP_J: begin
                w_legal = 1'b1;
                w_jump  = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Jump targets are absolute, so they are zero-extended; everything else is signed.
    assign w_imm = w_jump ? {{(DW-6){1'b0}}, w_imm6} : {{(DW-6){w_imm6[5]}}, w_imm6};

    // Register file: r0 is never written and always reads as zero.
    logic [DW-1:0] r_regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    logic [DW-1:0] w_rs_data;
    logic [DW-1:0] w_rt_data;

    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (w_rs != '0) begin
            w_rs_data = (wb_we && (wb_addr == w_rs)) ? wb_data : r_regs[w_rs];
        end
        if (w_rt != '0) begin
            w_rt_data = (wb_we && (wb_addr == w_rt)) ? wb_data : r_regs[w_rt];
        end
    end

    // ID/EX pipeline register
    logic          r_ex_valid;
    logic [PCW-1:0] r_ex_pc;
    logic [DW-1:0] r_ex_rs_data;
    logic [DW-1:0] r_ex_rt_data;
    logic [DW-1:0] r_ex_imm;
    logic [AW-1:0] r_ex_rs;
    logic [AW-1:0] r_ex_rt;
    logic [AW-1:0] r_ex_dest;
    logic [2:0]    r_ex_alu_op;
    logic          r_ex_alu_src;
    logic          r_ex_mem_read;
    logic          r_ex_mem_write;
    logic          r_ex_reg_write;
    logic          r_ex_branch;
    logic          r_ex_jump;

    // Load-use hazard: only sources the decoded instruction actually reads can match.
    logic w_match;
    logic w_stall;
    logic w_load;

    assign w_match = (w_uses_rs && (r_ex_rt == w_rs)) || (w_uses_rt && (r_ex_rt == w_rt));
    assign w_stall = r_ex_valid & r_ex_mem_read & (r_ex_rt != '0) & id_valid & ~flush & w_match;
    assign stall   = w_stall;

    // Flush, stall, an empty latch or an illegal encoding all load a bubble.
    assign w_load = ~flush & ~w_stall & id_valid & w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= '0;
            r_ex_rs_data   <= '0;
            r_ex_rt_data   <= '0;
            r_ex_imm       <= '0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_dest      <= '0;
            r_ex_alu_op    <= 3'b000;
            r_ex_alu_src   <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_branch    <= 1'b0;
            r_ex_jump      <= 1'b0;
        end else if (w_load) begin
            r_ex_valid     <= 1'b1;
            r_ex_pc        <= id_pc;
            r_ex_rs_data   <= w_rs_data;
            r_ex_rt_data   <= w_rt_data;
            r_ex_imm       <= w_imm;
            r_ex_rs        <= w_rs;
            r_ex_rt        <= w_rt;
            r_ex_dest      <= w_dest;
            r_ex_alu_op    <= w_alu_op;
            r_ex_alu_src   <= w_alu_src;
            r_ex_mem_read  <= w_mem_read;
            r_ex_mem_write <= w_mem_write;
            r_ex_reg_write <= w_reg_write;
            r_ex_branch    <= w_branch;
            r_ex_jump      <= w_jump;
        end else begin
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= '0;
            r_ex_rs_data   <= '0;
            r_ex_rt_data   <= '0;
            r_ex_imm       <= '0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_dest      <= '0;
            r_ex_alu_op    <= 3'b000;
            r_ex_alu_src   <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_branch    <= 1'b0;
            r_ex_jump      <= 1'b0;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_pc        = r_ex_pc;
    assign ex_rs_data   = r_ex_rs_data;
    assign ex_rt_data   = r_ex_rt_data;
    assign ex_imm       = r_ex_imm;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign ex_dest      = r_ex_dest;
    assign ex_alu_op    = r_ex_alu_op;
    assign ex_alu_src   = r_ex_alu_src;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_mem_write = r_ex_mem_write;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_branch    = r_ex_branch;
    assign ex_jump      = r_ex_jump;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized instruction streams,
// checked against a behavioural decode/register-file model.
module tb_id_stage;
    logic        clk;
    logic        rst_n;
    logic [5:0]  id_pc;
    logic [15:0] id_inst;
    logic        id_valid;
    logic        flush;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [5:0]  ex_pc;
    logic [15:0] ex_rs_data;
    logic [15:0] ex_rt_data;
    logic [15:0] ex_imm;
    logic [2:0]  ex_rs;
    logic [2:0]  ex_rt;
    logic [2:0]  ex_dest;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_branch;
    logic        ex_jump;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_jump(ex_jump)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [5:0]  pc;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  dest;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
    } ex_t;

    ex_t         m_ex;
    logic [15:0] m_regs [8];
    int          n_checks = 0;
    int          n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    function automatic bit m_legal(input logic [15:0] inst);
        int op;
        op = int'(inst[15:12]);
        if (op == 0) return int'(inst[2:0]) <= 4;
        return (op >= 1) && (op <= 5);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        if (wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_stall();
        int op;
        bit reads_rs, reads_rt;
        op = int'(id_inst[15:12]);
        reads_rs = m_legal(id_inst) && op != 5;
        reads_rt = m_legal(id_inst) && (op == 0 || op == 3 || op == 4);
        if (!(m_ex.valid && m_ex.mem_read && m_ex.rt != 0 && id_valid && !flush)) return 0;
        return (reads_rs && m_ex.rt == id_inst[11:9]) || (reads_rt && m_ex.rt == id_inst[8:6]);
    endfunction

    function automatic ex_t m_decode(input bit stl);
        ex_t e;
        int  op;
        int  s;
        e  = '0;
        op = int'(id_inst[15:12]);
        if (flush || stl || !id_valid || !m_legal(id_inst)) return e;
        e.valid   = 1;
        e.pc      = id_pc;
        e.rs      = id_inst[11:9];
        e.rt      = id_inst[8:6];
        e.rs_data = m_read(e.rs);
        e.rt_data = m_read(e.rt);
        s = int'(id_inst[5:0]);
        if (op != 5 && s >= 32) s = s - 64;
        e.imm = 16'(s);
        case (op)
            0: begin e.alu_op = id_inst[2:0]; e.dest = id_inst[5:3]; e.reg_write = 1; end
            1: begin e.alu_src = 1; e.dest = id_inst[8:6]; e.reg_write = 1; end
            2: begin e.alu_src = 1; e.mem_read = 1; e.dest = id_inst[8:6]; e.reg_write = 1; end
            3: begin e.alu_src = 1; e.mem_write = 1; end
            4: begin e.alu_op = 3'd1; e.branch = 1; end
            default: e.jump = 1;
        endcase
        return e;
    endfunction

    task automatic model_reset();
        m_ex = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    endtask

    task automatic check_ex(input string tag);
        check({tag, ".valid"},     ex_valid,     m_ex.valid);
        check({tag, ".pc"},        ex_pc,        m_ex.pc);
        check({tag, ".rs_data"},   ex_rs_data,   m_ex.rs_data);
        check({tag, ".rt_data"},   ex_rt_data,   m_ex.rt_data);
        check({tag, ".imm"},       ex_imm,       m_ex.imm);
        check({tag, ".rs"},        ex_rs,        m_ex.rs);
        check({tag, ".rt"},        ex_rt,        m_ex.rt);
        check({tag, ".dest"},      ex_dest,      m_ex.dest);
        check({tag, ".alu_op"},    ex_alu_op,    m_ex.alu_op);
        check({tag, ".alu_src"},   ex_alu_src,   m_ex.alu_src);
        check({tag, ".mem_read"},  ex_mem_read,  m_ex.mem_read);
        check({tag, ".mem_write"}, ex_mem_write, m_ex.mem_write);
        check({tag, ".reg_write"}, ex_reg_write, m_ex.reg_write);
        check({tag, ".branch"},    ex_branch,    m_ex.branch);
        check({tag, ".jump"},      ex_jump,      m_ex.jump);
    endtask

    // Driver: call just after a rising edge. Drives one cycle, checks stall
    // mid-cycle and the ID/EX register after the next edge.
    task automatic cycle(input string tag, input logic [15:0] inst, input logic [5:0] pc,
                         input logic v, input logic fl, input logic we,
                         input logic [2:0] wa, input logic [15:0] wd, output bit stl);
        id_inst = inst; id_pc = pc; id_valid = v; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
        @(negedge clk);
        stl = m_stall();
        check({tag, ".stall"}, stall, stl);
        m_ex = m_decode(stl);
        if (we && wa != 0) m_regs[wa] = wd;
        @(posedge clk);
        #1;
        check_ex(tag);
    endtask

    function automatic logic [15:0] rand_inst();
        int k;
        logic [15:0] r;
        k = $urandom_range(0, 8);
        r = 16'($urandom);
        case (k)
            0, 1: r[15:12] = 4'h0;
            2:    r[15:12] = 4'h1;
            3, 4: r[15:12] = 4'h2;
            5:    r[15:12] = 4'h3;
            6:    r[15:12] = 4'h4;
            7:    r[15:12] = 4'h5;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        bit          stl;
        logic [15:0] inst;
        logic [5:0]  pc;

        rst_n = 1'b0; id_pc = '0; id_inst = '0; id_valid = 0; flush = 0;
        wb_we = 0; wb_addr = '0; wb_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.stall", stall, 1'b0);
        check_ex("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Registers read zero after reset
        for (int i = 1; i < 8; i++) begin
            cycle("rf_zero", {4'h0, 3'(i), 3'(i), 3'd0, 3'd0}, 6'd0, 1, 0, 0, 3'd0, 16'h0, stl);
            check("rf_zero.rs_data", ex_rs_data, 16'h0000);
        end

        // Basic decode
        cycle("wb_r1", 16'h0000, 6'd0, 0, 0, 1, 3'd1, 16'h0005, stl);
        cycle("addi", 16'h1045, 6'd4, 1, 0, 0, 3'd0, 16'h0, stl);
        check("addi.dest_k", ex_dest, 3'd1);
        check("addi.imm_k", ex_imm, 16'h0005);
        check("addi.pc_k", ex_pc, 6'd4);

        // Sign extension + same-cycle bypass
        cycle("bypass", 16'h127F, 6'd6, 1, 0, 1, 3'd1, 16'h1234, stl);
        check("bypass.rs_data_k", ex_rs_data, 16'h1234);
        check("bypass.imm_k", ex_imm, 16'hFFFF);

        // Load-use hazard: exactly one stall cycle, then the add issues
        cycle("lw", 16'h2280, 6'd8, 1, 0, 0, 3'd0, 16'h0, stl);
        cycle("use1", 16'h0458, 6'd10, 1, 0, 0, 3'd0, 16'h0, stl);
        check("use1.stall_k", stl, 1'b1);
        check("use1.bubble_k", ex_valid, 1'b0);
        cycle("use2", 16'h0458, 6'd10, 1, 0, 0, 3'd0, 16'h0, stl);
        check("use2.stall_k", stl, 1'b0);
        check("use2.rs_k", ex_rs, 3'd2);
        check("use2.rt_k", ex_rt, 3'd1);
        check("use2.dest_k", ex_dest, 3'd3);

        // Flush overrides the hazard
        cycle("lw2", 16'h2280, 6'd12, 1, 0, 0, 3'd0, 16'h0, stl);
        cycle("flush", 16'h0458, 6'd14, 1, 1, 0, 3'd0, 16'h0, stl);
        check("flush.stall_k", stl, 1'b0);
        check("flush.valid_k", ex_valid, 1'b0);

        // r0 write ignored, illegal opcode bubbles
        cycle("wb_r0", 16'h0000, 6'd0, 0, 0, 1, 3'd0, 16'hBEEF, stl);
        cycle("rd_r0", 16'h0000, 6'd16, 1, 0, 0, 3'd0, 16'h0, stl);
        check("rd_r0.rs_data_k", ex_rs_data, 16'h0000);
        cycle("illegal", 16'hF000, 6'd18, 1, 0, 0, 3'd0, 16'h0, stl);
        check("illegal.valid_k", ex_valid, 1'b0);

        // Randomized stream; IF/ID holds on stall
        inst = rand_inst();
        pc   = 6'($urandom);
        for (int n = 0; n < 600; n++) begin
            cycle("rand", inst, pc, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
                  1'($urandom), 3'($urandom), 16'($urandom), stl);
            if (!stl) begin
                inst = rand_inst();
                pc   = pc + 6'd2;
            end
        end

        // Asynchronous reset mid-operation, no clock edge needed
        cycle("pre_rst", 16'h1047, 6'd20, 1, 0, 1, 3'd3, 16'h00AA, stl);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("async_rst.stall", stall, 1'b0);
        check_ex("async_rst");
        rst_n = 1'b1;
        for (int i = 1; i < 8; i++) begin
            cycle("rf_zero2", {4'h0, 3'(i), 3'(i), 3'd0, 3'd0}, 6'd0, 1, 0, 0, 3'd0, 16'h0, stl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
